// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: registers commands onto the ALU inputs,
// captures the settled result one cycle later and drains it over a valid/ready port.
module alu_cmd_sequencer #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 64,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [OUT_W-1:0]  alu_out,
  input  logic              alu_sign,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_sign,
  output logic              res_zero,
  output logic [OP_W-1:0]   res_op,
  output logic              res_illegal,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [OP_W-1:0] OP_ILLEGAL = OP_W'(3'b100);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r;
  logic   cmd_fire_s;
  logic   res_fire_s;

  // A new command may overlap the drain of the previous result.
  assign cmd_ready  = (state_r == IDLE) || ((state_r == RESP) && res_ready);
  assign cmd_fire_s = cmd_valid && cmd_ready;
  assign res_fire_s = res_valid && res_ready;
  assign busy       = (state_r != IDLE);

  // Sequencer FSM with registered ALU operands and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_sign    <= 1'b0;
      res_zero    <= 1'b0;
      res_op      <= '0;
      res_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_fire_s) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_op  <= cmd_op;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          res_data    <= alu_out;
          res_sign    <= alu_sign;
          res_zero    <= alu_zero;
          res_op      <= alu_op;
          res_illegal <= (alu_op == OP_ILLEGAL);
          res_valid   <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (res_fire_s) begin
            op_count  <= op_count + CNT_W'(1);
            res_valid <= 1'b0;
            if (cmd_fire_s) begin
              alu_a   <= cmd_a;
              alu_b   <= cmd_b;
              alu_op  <= cmd_op;
              state_r <= EXEC;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed bench for alu_cmd_sequencer against a queue-based
// transaction model; a behavioural ALU closes the loop on the alu_* ports.
module tb_alu_cmd_sequencer;

  localparam int DATA_W = 32;
  localparam int OUT_W  = 64;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [OUT_W-1:0]  alu_out;
  logic              alu_sign;
  logic              alu_zero;
  logic              res_valid;
  logic              res_ready;
  logic [OUT_W-1:0]  res_data;
  logic              res_sign;
  logic              res_zero;
  logic [OP_W-1:0]   res_op;
  logic              res_illegal;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  op;
    int          rdy;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          cnt    = 0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;
  logic [2:0]  last_op = 3'd0;

  alu_cmd_sequencer #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_sign(alu_sign), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sign(res_sign), .res_zero(res_zero),
    .res_op(res_op), .res_illegal(res_illegal),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = {32'h0, a};
    xb = {32'h0, b};
    case (op)
      3'b000:  return xa + xb;
      3'b001:  return xa - xb;
      3'b010:  return xa * xb;
      3'b011:  return xa & xb;
      3'b100:  return 64'h0;
      3'b101:  return xa | xb;
      3'b110:  return xa ^ xb;
      default: return {b, a};
    endcase
  endfunction

  assign alu_out  = alu_ref(alu_a, alu_b, alu_op);
  assign alu_sign = alu_out[63];
  assign alu_zero = (alu_out == 64'h0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample and score at the falling edge, then return just after the rising edge.
  task automatic step();
    logic ev;
    logic ex;
    logic ecr;
    exp_t e;
    @(negedge clk);
    ev = 1'b0;
    ex = 1'b0;
    if (q.size() > 0) begin
      if (q[0].rdy <= cyc) ev = 1'b1;
      else ex = 1'b1;
    end
    ecr = !ex && (!ev || res_ready);
    chk("res_valid", res_valid, ev);
    chk("cmd_ready", cmd_ready, ecr);
    chk("busy", busy, (q.size() > 0));
    chk("op_count", op_count, cnt);
    chk("alu_a", alu_a, last_a);
    chk("alu_b", alu_b, last_b);
    chk("alu_op", alu_op, last_op);
    if (ev) begin
      chk("res_data", res_data, q[0].data);
      chk("res_sign", res_sign, q[0].data[63]);
      chk("res_zero", res_zero, (q[0].data == 64'h0));
      chk("res_op", res_op, q[0].op);
      chk("res_illegal", res_illegal, (q[0].op == 3'b100));
      if (res_ready) begin
        void'(q.pop_front());
        cnt = (cnt + 1) % (1 << CNT_W);
      end
    end
    if (cmd_valid && ecr) begin
      e.data  = alu_ref(cmd_a, cmd_b, cmd_op);
      e.op    = cmd_op;
      e.rdy   = cyc + 2;
      q.push_back(e);
      last_a  = cmd_a;
      last_b  = cmd_b;
      last_op = cmd_op;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    cmd_op    = 3'd0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);

    // T1 add
    drive_cmd(32'd5, 32'd7, 3'b000);
    step();
    cmd_valid = 1'b0;
    step();
    chk("t1_valid", res_valid, 1'b1);
    chk("t1_data", res_data, 64'd12);
    chk("t1_sign", res_sign, 1'b0);
    chk("t1_zero", res_zero, 1'b0);
    res_ready = 1'b1;
    step();
    chk("t1_count", op_count, 1);
    res_ready = 1'b0;

    // T2 subtract to negative
    drive_cmd(32'd3, 32'd5, 3'b001);
    step();
    cmd_valid = 1'b0;
    step();
    chk("t2_data", res_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2_sign", res_sign, 1'b1);
    chk("t2_zero", res_zero, 1'b0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // T3 backpressure with a waiting command
    drive_cmd(32'd10, 32'd20, 3'b010);
    step();
    drive_cmd(32'd99, 32'd1, 3'b000);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_data", res_data, 64'd200);
      chk("t3_alu_a", alu_a, 32'd10);
      chk("t3_cmd_ready", cmd_ready, 1'b0);
      step();
    end
    res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t3_next", res_data, 64'd100);
    step();
    chk("t3_count", op_count, 4);

    // T4 back-to-back
    for (int i = 0; i < 4; i++) begin
      drive_cmd(32'(i * 11 + 1), 32'(i + 2), 3'(i));
      step();
      step();
    end
    cmd_valid = 1'b0;
    step();
    step();
    chk("t4_count", op_count, 8);
    res_ready = 1'b0;

    // T5 unassigned opcode
    drive_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100);
    step();
    cmd_valid = 1'b0;
    step();
    chk("t5_data", res_data, 64'h0);
    chk("t5_zero", res_zero, 1'b1);
    chk("t5_illegal", res_illegal, 1'b1);
    chk("t5_op", res_op, 3'b100);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Random traffic, long enough to wrap the narrow counter
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_a     = $urandom();
      cmd_b     = ($urandom_range(0, 3) == 0) ? cmd_a : $urandom();
      cmd_op    = 3'($urandom_range(0, 7));
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // T6 reset in EXEC
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (3) step();
    res_ready = 1'b0;
    drive_cmd(32'd40, 32'd2, 3'b000);
    step();
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_res_valid", res_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_alu_a", alu_a, 0);
    chk("t6_alu_b", alu_b, 0);
    chk("t6_alu_op", alu_op, 0);
    chk("t6_op_count", op_count, 0);
    chk("t6_res_data", res_data, 0);
    q.delete();
    cnt     = 0;
    last_a  = 32'd0;
    last_b  = 32'd0;
    last_op = 3'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t6_cmd_ready", cmd_ready, 1'b1);
    drive_cmd(32'd1, 32'd2, 3'b000);
    res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t6_data", res_data, 64'd3);
    step();
    chk("t6_count", op_count, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
